// File: rtl/grf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : grf_wb_arbiter
// Description : Arbitrates the single GRF write port between the pipeline
//               W stage (primary, fixed priority, never back-pressured) and a
//               long-latency result source (secondary, valid/ready) buffered
//               in a small FIFO. Keeps a per-register scoreboard of results
//               still outstanding and requests a one-cycle pipeline freeze
//               when the FIFO head has been starved for too long.
//
// Parameters  : DEPTH      - secondary FIFO entries (power of 2, >= 2)
//               STARVE_MAX - blocked cycles tolerated before stall_req (>= 1)
//
// Ports       : clk, reset                 - clock, sync active-high reset
//               w_we/w_a3/w_wd/w_pc        - W-stage write request
//               s_valid/s_ready/s_a3/s_wd/s_pc - secondary result handshake
//               iss_valid/iss_a3           - long-latency issue, marks pending
//               q_a1/q_a2 -> busy1/busy2   - scoreboard read queries
//               stall_req                  - freeze pipeline so the head drains
//               grf_we/grf_a3/grf_wd/grf_pc - GRF write port (pc for trace)
//
// Options     : GRF_WB_TRACE_EN - when defined, prints every committed
//               non-zero-register write (simulation only).
//
// Revision    : 1.0 - initial release
// ============================================================================
module grf_wb_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        w_we,
    input  logic [4:0]  w_a3,
    input  logic [31:0] w_wd,
    input  logic [31:0] w_pc,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [4:0]  s_a3,
    input  logic [31:0] s_wd,
    input  logic [31:0] s_pc,
    input  logic        iss_valid,
    input  logic [4:0]  iss_a3,
    input  logic [4:0]  q_a1,
    input  logic [4:0]  q_a2,
    output logic        busy1,
    output logic        busy2,
    output logic        stall_req,
    output logic        grf_we,
    output logic [4:0]  grf_a3,
    output logic [31:0] grf_wd,
    output logic [31:0] grf_pc
);

    localparam int c_PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W   = $clog2(DEPTH + 1);
    localparam int c_STARVE_W = $clog2(STARVE_MAX + 1);

    localparam logic [c_CNT_W-1:0]    c_DEPTH_CNT  = c_CNT_W'(DEPTH);
    localparam logic [c_STARVE_W-1:0] c_STARVE_LIM = c_STARVE_W'(STARVE_MAX);

    typedef struct packed {
        logic [4:0]  a3;
        logic [31:0] wd;
        logic [31:0] pc;
    } entry_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    entry_t                r_fifo_q [DEPTH];
    entry_t                w_fifo_d [DEPTH];
    logic [c_PTR_W-1:0]    r_wr_ptr_q, w_wr_ptr_d;
    logic [c_PTR_W-1:0]    r_rd_ptr_q, w_rd_ptr_d;
    logic [c_CNT_W-1:0]    r_count_q,  w_count_d;
    logic [31:0]           r_pending_q, w_pending_d;
    logic [c_STARVE_W-1:0] r_starve_q, w_starve_d;

    logic   w_push;
    logic   w_pop;
    logic   w_not_empty;
    entry_t w_head;

    assign w_not_empty = (r_count_q != '0);
    assign w_head      = r_fifo_q[r_rd_ptr_q];

    // Readiness depends only on the registered count: a same-cycle pop does
    // not free a slot, so there is no combinational path from w_we to s_ready.
    assign s_ready = (r_count_q < c_DEPTH_CNT);
    assign w_push  = s_valid & s_ready;
    // The head commits whenever the W stage leaves the port idle.
    assign w_pop   = ~w_we & w_not_empty;

    // ------------------------------------------------------------------------
    // GRF port grant
    // ------------------------------------------------------------------------
    always_comb begin
        grf_we = 1'b0;
        grf_a3 = 5'd0;
        grf_wd = 32'd0;
        grf_pc = 32'd0;
        if (w_we) begin
            grf_we = 1'b1;
            grf_a3 = w_a3;
            grf_wd = w_wd;
            grf_pc = w_pc;
        end else if (w_not_empty) begin
            grf_we = 1'b1;
            grf_a3 = w_head.a3;
            grf_wd = w_head.wd;
            grf_pc = w_head.pc;
        end
    end

    // ------------------------------------------------------------------------
    // Scoreboard queries and starvation request
    // ------------------------------------------------------------------------
    assign busy1     = r_pending_q[q_a1] & (q_a1 != 5'd0);
    assign busy2     = r_pending_q[q_a2] & (q_a2 != 5'd0);
    assign stall_req = (r_starve_q >= c_STARVE_LIM);

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_fifo_d   = r_fifo_q;
        w_wr_ptr_d = r_wr_ptr_q;
        w_rd_ptr_d = r_rd_ptr_q;
        w_count_d  = r_count_q;

        if (w_push) begin
            w_fifo_d[r_wr_ptr_q] = '{a3: s_a3, wd: s_wd, pc: s_pc};
            // DEPTH is a power of two, so natural overflow wraps the pointer.
            w_wr_ptr_d = r_wr_ptr_q + c_PTR_W'(1);
        end
        if (w_pop) begin
            w_rd_ptr_d = r_rd_ptr_q + c_PTR_W'(1);
        end

        case ({w_push, w_pop})
            2'b10:   w_count_d = r_count_q + c_CNT_W'(1);
            2'b01:   w_count_d = r_count_q - c_CNT_W'(1);
            default: w_count_d = r_count_q;
        endcase
    end

    always_comb begin
        w_pending_d = r_pending_q;
        if (w_pop) begin
            w_pending_d[w_head.a3] = 1'b0;
        end
        // Applied after the clear so that a same-cycle issue wins.
        if (iss_valid && (iss_a3 != 5'd0)) begin
            w_pending_d[iss_a3] = 1'b1;
        end
    end

    always_comb begin
        w_starve_d = r_starve_q;
        if (!w_not_empty || w_pop) begin
            w_starve_d = '0;
        end else if (r_starve_q != c_STARVE_LIM) begin
            // Saturates so a misbehaving W stage cannot wrap the counter
            // and silently drop the freeze request.
            w_starve_d = r_starve_q + c_STARVE_W'(1);
        end
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_q[i] <= '0;
            end
            r_wr_ptr_q  <= '0;
            r_rd_ptr_q  <= '0;
            r_count_q   <= '0;
            r_pending_q <= '0;
            r_starve_q  <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                r_fifo_q[i] <= w_fifo_d[i];
            end
            r_wr_ptr_q  <= w_wr_ptr_d;
            r_rd_ptr_q  <= w_rd_ptr_d;
            r_count_q   <= w_count_d;
            r_pending_q <= w_pending_d;
            r_starve_q  <= w_starve_d;
        end
    end

    // ------------------------------------------------------------------------
    // Commit trace
    // ------------------------------------------------------------------------
`ifdef GRF_WB_TRACE_EN
    always @(posedge clk) begin
        if (grf_we && (grf_a3 != 5'd0)) begin
            $display("%d@%h: $%d <= %h", $time, grf_pc, grf_a3, grf_wd);
        end
    end
`else
    // Trace disabled: no simulation-only code is elaborated.
`endif

endmodule
`default_nettype wire
